// File: rtl/alarm_system_timed.sv
// Timed door/alarm controller: lock/close commands, auto-arming after a dwell,
// and a sound-then-flash alarm sequence with a saturating trigger counter.
module alarm_system_timed #(
    parameter int ARM_CYCLES   = 20,
    parameter int SOUND_CYCLES = 30,
    parameter int FLASH_CYCLES = 270,
    parameter int TIMER_W      = 9,
    parameter int EVT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic [2:0]       state,
    output logic             sound,
    output logic             flash,
    output logic             alarm,
    output logic             armed,
    output logic [EVT_W-1:0] alarm_events
);

    typedef enum logic [2:0] {
        S_OPEN_UNLOCKED   = 3'd0,
        S_OPEN_LOCKED     = 3'd1,
        S_CLOSED_UNLOCKED = 3'd2,
        S_CLOSED_LOCKED   = 3'd3,
        S_ARMED           = 3'd4,
        S_ALARM_FS        = 3'd5,
        S_ALARM_F         = 3'd6,
        S_ILLEGAL         = 3'd7
    } state_e;

    localparam logic [TIMER_W-1:0] ARM_LAST   = TIMER_W'(ARM_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SOUND_LAST = TIMER_W'(SOUND_CYCLES - 1);
    localparam logic [TIMER_W-1:0] FLASH_LAST = TIMER_W'(FLASH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = {TIMER_W{1'b1}};
    localparam logic [EVT_W-1:0]   EVT_MAX    = {EVT_W{1'b1}};

    state_e             state_r, next_state_s;
    logic [TIMER_W-1:0] timer_r, next_timer_s;
    logic               sound_r, next_sound_s;
    logic               flash_r, next_flash_s;
    logic               alarm_r, next_alarm_s;
    logic               armed_r, next_armed_s;
    logic [EVT_W-1:0]   events_r, next_events_s;
    logic               do_close_s, do_open_s, do_lock_s, do_unlock_s, timed_s;

    assign do_close_s  = cmd_valid && (cmd == 2'd0);
    assign do_open_s   = cmd_valid && (cmd == 2'd1);
    assign do_lock_s   = cmd_valid && (cmd == 2'd2);
    assign do_unlock_s = cmd_valid && (cmd == 2'd3);
    assign timed_s     = (state_r == S_CLOSED_LOCKED) || (state_r == S_ALARM_FS) ||
                         (state_r == S_ALARM_F);

    // Next-state and next-output decode; transitioning commands win over expiry.
    always_comb begin
        next_state_s  = state_r;
        next_sound_s  = sound_r;
        next_flash_s  = flash_r;
        next_alarm_s  = alarm_r;
        next_events_s = events_r;
        case (state_r)
            S_OPEN_UNLOCKED: begin
                if (do_close_s)     next_state_s = S_CLOSED_UNLOCKED;
                else if (do_lock_s) next_state_s = S_OPEN_LOCKED;
                else                next_state_s = state_r;
            end
            S_OPEN_LOCKED: begin
                if (do_close_s)       next_state_s = S_CLOSED_LOCKED;
                else if (do_unlock_s) next_state_s = S_OPEN_UNLOCKED;
                else                  next_state_s = state_r;
            end
            S_CLOSED_UNLOCKED: begin
                if (do_open_s)      next_state_s = S_OPEN_UNLOCKED;
                else if (do_lock_s) next_state_s = S_CLOSED_LOCKED;
                else                next_state_s = state_r;
            end
            S_CLOSED_LOCKED: begin
                if (do_open_s)                 next_state_s = S_OPEN_LOCKED;
                else if (do_unlock_s)          next_state_s = S_CLOSED_UNLOCKED;
                else if (timer_r == ARM_LAST)  next_state_s = S_ARMED;
                else                           next_state_s = state_r;
            end
            S_ARMED: begin
                if (do_open_s) begin
                    next_state_s  = S_ALARM_FS;
                    next_sound_s  = 1'b1;
                    next_flash_s  = 1'b1;
                    next_alarm_s  = 1'b1;
                    next_events_s = (events_r == EVT_MAX) ? events_r : events_r + EVT_W'(1);
                end else if (do_unlock_s) begin
                    // A disarm after a fired alarm leaves the door treated as open.
                    next_state_s = alarm_r ? S_OPEN_UNLOCKED : S_CLOSED_UNLOCKED;
                    next_sound_s = 1'b0;
                    next_flash_s = 1'b0;
                    next_alarm_s = 1'b0;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_ALARM_FS, S_ALARM_F: begin
                if (do_unlock_s) begin
                    next_state_s = S_OPEN_UNLOCKED;
                    next_sound_s = 1'b0;
                    next_flash_s = 1'b0;
                    next_alarm_s = 1'b0;
                end else if ((state_r == S_ALARM_FS) && (timer_r == SOUND_LAST)) begin
                    next_state_s = S_ALARM_F;
                    next_sound_s = 1'b0;
                end else if ((state_r == S_ALARM_F) && (timer_r == FLASH_LAST)) begin
                    next_state_s = S_ARMED;
                    next_flash_s = 1'b0;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s  = S_OPEN_UNLOCKED;
                next_sound_s  = 1'b0;
                next_flash_s  = 1'b0;
                next_alarm_s  = 1'b0;
                next_events_s = {EVT_W{1'b0}};
            end
        endcase
    end

    // Dwell timer and armed flag derived from the upcoming state.
    always_comb begin
        next_timer_s = timer_r;
        if (next_state_s != state_r)             next_timer_s = {TIMER_W{1'b0}};
        else if (timed_s && timer_r != TIMER_MAX) next_timer_s = timer_r + TIMER_W'(1);
        else                                      next_timer_s = timer_r;
        next_armed_s = (next_state_s == S_ARMED) || (next_state_s == S_ALARM_FS) ||
                       (next_state_s == S_ALARM_F);
    end

    // State, timer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_OPEN_UNLOCKED;
            timer_r  <= {TIMER_W{1'b0}};
            sound_r  <= 1'b0;
            flash_r  <= 1'b0;
            alarm_r  <= 1'b0;
            armed_r  <= 1'b0;
            events_r <= {EVT_W{1'b0}};
        end else begin
            state_r  <= next_state_s;
            timer_r  <= next_timer_s;
            sound_r  <= next_sound_s;
            flash_r  <= next_flash_s;
            alarm_r  <= next_alarm_s;
            armed_r  <= next_armed_s;
            events_r <= next_events_s;
        end
    end

    assign state        = state_r;
    assign sound        = sound_r;
    assign flash        = flash_r;
    assign alarm        = alarm_r;
    assign armed        = armed_r;
    assign alarm_events = events_r;

endmodule

// File: tb/tb_alarm_system_timed.sv
// Directed bench for alarm_system_timed with short dwell times (ARM=4, SOUND=3, FLASH=5, EVT_W=2).
module tb_alarm_system_timed;

    localparam logic [1:0] C_CLOSE  = 2'd0;
    localparam logic [1:0] C_OPEN   = 2'd1;
    localparam logic [1:0] C_LOCK   = 2'd2;
    localparam logic [1:0] C_UNLOCK = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [2:0] state;
    logic       sound, flash, alarm, armed;
    logic [1:0] alarm_events;

    int n_checks = 0;
    int n_errors = 0;

    alarm_system_timed #(
        .ARM_CYCLES(4), .SOUND_CYCLES(3), .FLASH_CYCLES(5), .TIMER_W(9), .EVT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
        .state(state), .sound(sound), .flash(flash), .alarm(alarm),
        .armed(armed), .alarm_events(alarm_events)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] c);
        rst = r; cmd_valid = v; cmd = c;
        @(posedge clk);
        #1;
        rst = 1'b0; cmd_valid = 1'b0; cmd = 2'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0);
    endtask

    task automatic arm_from_open;
        step(1'b0, 1'b1, C_CLOSE);
        step(1'b0, 1'b1, C_LOCK);
        idle(4);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'd0;
        step(1'b1, 1'b1, C_CLOSE);
        check("rst_state", 32'(state), 32'd0);
        check("rst_sound", 32'(sound), 32'd0);
        check("rst_flash", 32'(flash), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_events", 32'(alarm_events), 32'd0);

        step(1'b0, 1'b1, C_CLOSE);
        check("close_state", 32'(state), 32'd2);
        step(1'b0, 1'b1, C_LOCK);
        check("lock_state", 32'(state), 32'd3);
        idle(3);
        check("dwell3_state", 32'(state), 32'd3);
        check("dwell3_armed", 32'(armed), 32'd0);
        idle(1);
        check("arm_state", 32'(state), 32'd4);
        check("arm_armed", 32'(armed), 32'd1);

        step(1'b0, 1'b1, C_OPEN);
        check("trig_state", 32'(state), 32'd5);
        check("trig_sound", 32'(sound), 32'd1);
        check("trig_flash", 32'(flash), 32'd1);
        check("trig_alarm", 32'(alarm), 32'd1);
        check("trig_events", 32'(alarm_events), 32'd1);
        idle(2);
        check("fs2_state", 32'(state), 32'd5);
        idle(1);
        check("f_state", 32'(state), 32'd6);
        check("f_sound", 32'(sound), 32'd0);
        check("f_flash", 32'(flash), 32'd1);
        idle(4);
        check("f4_state", 32'(state), 32'd6);
        idle(1);
        check("rearm_state", 32'(state), 32'd4);
        check("rearm_flash", 32'(flash), 32'd0);
        check("rearm_alarm", 32'(alarm), 32'd1);
        check("rearm_armed", 32'(armed), 32'd1);

        step(1'b0, 1'b1, C_UNLOCK);
        check("unl_alarm_state", 32'(state), 32'd0);
        check("unl_alarm_alarm", 32'(alarm), 32'd0);
        check("unl_alarm_armed", 32'(armed), 32'd0);

        arm_from_open();
        check("arm2_state", 32'(state), 32'd4);
        check("arm2_alarm", 32'(alarm), 32'd0);
        step(1'b0, 1'b1, C_UNLOCK);
        check("unl_quiet_state", 32'(state), 32'd2);

        // Commands on the cycle the arming timer would expire.
        step(1'b0, 1'b1, C_LOCK);
        idle(3);
        step(1'b0, 1'b1, C_UNLOCK);
        check("exp_unlock_state", 32'(state), 32'd2);
        check("exp_unlock_armed", 32'(armed), 32'd0);
        step(1'b0, 1'b1, C_LOCK);
        idle(3);
        step(1'b0, 1'b1, C_OPEN);
        check("exp_open_state", 32'(state), 32'd1);
        step(1'b0, 1'b1, C_LOCK);
        check("unlisted_state", 32'(state), 32'd1);
        step(1'b0, 1'b0, C_CLOSE);
        check("invalid_state", 32'(state), 32'd1);
        step(1'b0, 1'b1, C_CLOSE);
        check("relock_state", 32'(state), 32'd3);
        idle(3);
        step(1'b0, 1'b1, C_CLOSE);
        check("exp_close_state", 32'(state), 32'd4);

        // Saturation of the event counter over four triggers.
        step(1'b1, 1'b0, 2'd0);
        check("rst2_events", 32'(alarm_events), 32'd0);
        arm_from_open();
        step(1'b0, 1'b1, C_OPEN);
        check("sat_ev1", 32'(alarm_events), 32'd1);
        idle(8);
        check("sat_rearm1", 32'(state), 32'd4);
        step(1'b0, 1'b1, C_OPEN);
        check("sat_ev2", 32'(alarm_events), 32'd2);
        check("sat_retrig_state", 32'(state), 32'd5);
        idle(8);
        step(1'b0, 1'b1, C_OPEN);
        check("sat_ev3", 32'(alarm_events), 32'd3);
        idle(8);
        step(1'b0, 1'b1, C_OPEN);
        check("sat_ev4", 32'(alarm_events), 32'd3);
        check("sat_state", 32'(state), 32'd5);
        check("sat_sound", 32'(sound), 32'd1);

        // Reset mid-alarm with a command present.
        step(1'b1, 1'b1, C_UNLOCK);
        check("rst_fs_state", 32'(state), 32'd0);
        check("rst_fs_sound", 32'(sound), 32'd0);
        check("rst_fs_flash", 32'(flash), 32'd0);
        check("rst_fs_alarm", 32'(alarm), 32'd0);
        check("rst_fs_armed", 32'(armed), 32'd0);
        check("rst_fs_events", 32'(alarm_events), 32'd0);
        step(1'b0, 1'b1, C_LOCK);
        check("post_rst_cmd", 32'(state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
